adc_block_averager: RTL and testbench
=====================================

# adc_block_averager

- Upstream stage of the feedback integrator.
- Takes single-cycle ADC sample strobes and averages blocks of 2^k signed samples (boxcar decimation).
- Presents each mean on `adc_data` with an `adc_valid` pulse stretched to several cycles, so the integrator's rising-edge detector sees exactly one edge per result.
- Also flags ADC over-range codes.

## Interface
- `ADC_WIDTH`, default 18: sample and output width, two's complement.
- `LOG2_MAX_AVG`, default 10: largest supported k; the accumulator is ADC_WIDTH+LOG2_MAX_AVG bits.
- `VALID_CYCLES`, default 4: number of cycles `adc_valid` stays high per result; minimum 1.
- `clk`, input, 1: single clock for the block.
- `resetn`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: low clears the accumulation and idles the block.
- `log2_avg`, input, 4: k, the block length as 2^k. Values above LOG2_MAX_AVG are clamped to LOG2_MAX_AVG.
- `in_valid`, input, 1: one-cycle strobe marking a new sample.
- `in_data`, input, ADC_WIDTH: signed sample, valid with `in_valid`.
- `clear_ovr`, input, 1: clears `overrange`.
- `adc_data`, output, ADC_WIDTH: signed mean of the last completed block.
- `adc_valid`, output, 1: stretched result strobe.
- `overrange`, output, 1: sticky flag; set when `in_valid` is high and `in_data` is the most-positive or most-negative code.

## Operation
- **Reset values:** `adc_data`=0, `adc_valid`=0, `overrange`=0. Accumulator, sample counter and latched k are all 0; FSM is in IDLE.
- **Block start:** on the first accepted `in_valid` of a block, k is latched from `log2_avg`. A change to `log2_avg` mid-block takes effect at the next block.
- **Accumulation:** each accepted sample is sign-extended and added to the accumulator. The counter increments.
- **Block completion:** on the sample that makes the count 2^k:
  - `adc_data` <= (acc + in_data) >>> k, using an arithmetic shift (floor rounding). The result always fits in ADC_WIDTH, so no saturation is needed.
  - Accumulator and counter clear in the same cycle, so no sample is lost.
- **k = 0:** every sample is a result, with `adc_data` = `in_data`.
- **Output FSM states:** IDLE, HOLD, GAP.
- **IDLE:**
  - `adc_valid`=0.
  - A new result moves to HOLD, with the hold counter loaded to VALID_CYCLES.
- **HOLD:**
  - `adc_valid`=1.
  - The counter decrements each cycle. When it reaches 1, the FSM goes to IDLE.
  - A new result arriving in HOLD updates `adc_data` and moves to GAP.
- **GAP:**
  - `adc_valid`=0 for exactly one cycle, then HOLD with the counter reloaded to VALID_CYCLES.
  - A further result arriving in GAP updates `adc_data` only. Last value wins.
- **`enable` low:**
  - Accumulator and counter clear, and `in_valid` is ignored.
  - The FSM drops to IDLE next cycle, with `adc_valid`=0.
  - `adc_data` holds its last value.
- **`enable` rising:** the next accepted sample starts a fresh block.
- **`overrange`:**
  - Sets on over-range codes regardless of `enable`.
  - `clear_ovr` clears it. When `clear_ovr` and a new over-range code occur in the same cycle, set wins.
- **Asynchronous reset mid-block:** discards the partial sum; all outputs return to their reset values immediately.

## Timing
- **Result latency:** the completing `in_valid` occurs at cycle t. `adc_data` is updated and `adc_valid` rises at t+1, and `adc_valid` stays high through t+VALID_CYCLES.
- **Registered outputs:** all outputs are registered, with no combinational input-to-output path.
- **Full throughput:** `in_valid` is accepted every cycle.
- **Clean edges:** results are spaced at least VALID_CYCLES+1 cycles apart, which guarantees one `adc_valid` edge per result. Closer spacing goes through GAP as described above.
- **`overrange` latency:** asserts at t+1 after the offending sample.

## Test plan
- **Reset and k=0:** reset, then k=0 with samples 100, -5 spaced 8 cycles apart.
  - Required: `adc_data` = 100 then -5, each at t+1.
  - Required: `adc_valid` high for 4 cycles each time, starting low after reset.
- **Floor rounding, k=2:** k=2, samples 1,2,3,3.
  - Required: sum 9, `adc_data`=2, one `adc_valid` pulse.
  - Then samples -1,-1,-1,-2: sum -5, `adc_data`=-2.
- **Full-scale blocks, k=10:** k=10, 1024 samples of +131071, then 1024 of -131072.
  - Required: `adc_data`=131071, then -131072, with no wrap.
  - Required: `overrange`=1, cleared by `clear_ovr`.
- **Back-to-back results:** k=0, `in_valid` high on 3 consecutive cycles with values 7, 8, 9.
  - Required: `adc_valid` pattern 1,0,1,1,1,1.
  - Required: final `adc_data`=9.
- **Mid-block disruptions:**
  - k=3: after 5 samples drop `enable` for 2 cycles, then feed 8 samples of 10. Required: `adc_data`=10.
  - Change `log2_avg` to 1 mid-block. Required: the current block still uses 8 samples.
- **Reset mid-hold:** assert `resetn` low during HOLD.
  - Required: `adc_valid`, `adc_data` and `overrange` all go to 0 immediately, with no pulse after release.

Source files
------------

// File: rtl/adc_block_averager.sv
`default_nettype none
// ============================================================================
// Module  : adc_block_averager
// Purpose : Boxcar-averages blocks of 2^k signed ADC samples and presents each
//           mean with a stretched valid strobe; flags over-range codes.
// Revision: 1.0 - initial release
// ============================================================================
module adc_block_averager #(
    parameter int ADC_WIDTH    = 18,
    parameter int LOG2_MAX_AVG = 10,
    parameter int VALID_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic [3:0]                  log2_avg,
    input  logic                        in_valid,
    input  logic signed [ADC_WIDTH-1:0] in_data,
    input  logic                        clear_ovr,
    output logic signed [ADC_WIDTH-1:0] adc_data,
    output logic                        adc_valid,
    output logic                        overrange
);

    localparam int c_ACC_W  = ADC_WIDTH + LOG2_MAX_AVG;
    localparam int c_CNT_W  = LOG2_MAX_AVG + 1;
    localparam int c_HOLD_W = $clog2(VALID_CYCLES + 1);
    localparam logic [3:0]                  c_K_MAX     = 4'(LOG2_MAX_AVG);
    localparam logic [c_HOLD_W-1:0]         c_HOLD_LOAD = c_HOLD_W'(VALID_CYCLES);
    localparam logic signed [ADC_WIDTH-1:0] c_CODE_MAX  = {1'b0, {(ADC_WIDTH-1){1'b1}}};
    localparam logic signed [ADC_WIDTH-1:0] c_CODE_MIN  = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                      state_q;
    logic [c_HOLD_W-1:0]         hold_q;
    logic signed [c_ACC_W-1:0]   acc_q, acc_d;
    logic [c_CNT_W-1:0]          cnt_q, cnt_d;
    logic [3:0]                  k_q, k_d;
    logic signed [ADC_WIDTH-1:0] data_q;
    logic                        valid_q;
    logic                        ovr_q;

    logic [3:0]                  w_k_req;
    logic [3:0]                  w_k;
    logic signed [c_ACC_W-1:0]   w_sum;
    logic [c_CNT_W-1:0]          w_cnt_inc;
    logic [c_CNT_W-1:0]          w_target;
    logic                        w_done;
    logic                        w_ovr_code;
    logic signed [ADC_WIDTH-1:0] w_mean;

    // k is only sampled from the port when a block starts (counter at zero).
    always_comb begin
        w_k_req    = (log2_avg > c_K_MAX) ? c_K_MAX : log2_avg;
        w_k        = (cnt_q == '0) ? w_k_req : k_q;
        w_sum      = acc_q + $signed({{LOG2_MAX_AVG{in_data[ADC_WIDTH-1]}}, in_data});
        w_cnt_inc  = cnt_q + c_CNT_W'(1);
        w_target   = c_CNT_W'(1) << w_k;
        w_done     = enable && in_valid && (w_cnt_inc == w_target);
        w_mean     = ADC_WIDTH'(w_sum >>> w_k);
        w_ovr_code = in_valid && ((in_data == c_CODE_MAX) || (in_data == c_CODE_MIN));

        acc_d = acc_q;
        cnt_d = cnt_q;
        k_d   = k_q;
        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            k_d = w_k;
            if (w_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = w_sum;
                cnt_d = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            hold_q  <= '0;
            state_q <= ST_IDLE;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            k_q   <= k_d;

            if (w_done) begin
                data_q <= w_mean;
            end

            if (w_ovr_code) begin
                ovr_q <= 1'b1;
            end else if (clear_ovr) begin
                ovr_q <= 1'b0;
            end

            // A result landing in HOLD forces a one-cycle low so the
            // downstream edge detector still sees a distinct rising edge.
            if (!enable) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
                hold_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_done) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                            hold_q  <= c_HOLD_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_done) begin
                            state_q <= ST_GAP;
                            valid_q <= 1'b0;
                        end else if (hold_q == c_HOLD_W'(1)) begin
                            state_q <= ST_IDLE;
                            valid_q <= 1'b0;
                        end else begin
                            hold_q <= hold_q - c_HOLD_W'(1);
                        end
                    end
                    ST_GAP: begin
                        state_q <= ST_HOLD;
                        valid_q <= 1'b1;
                        hold_q  <= c_HOLD_LOAD;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign adc_data  = data_q;
    assign adc_valid = valid_q;
    assign overrange = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_block_averager.sv
`default_nettype none
// ============================================================================
// Module  : tb_adc_block_averager
// Purpose : Self-checking bench for adc_block_averager with a queue/arithmetic
//           reference model for randomized blocks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adc_block_averager;

    localparam int c_W      = 18;
    localparam int c_VALIDN = 4;
    localparam logic signed [c_W-1:0] c_MAX = 18'sd131071;
    localparam logic signed [c_W-1:0] c_MIN = -18'sd131072;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  enable = 1'b0;
    logic [3:0]            log2_avg = 4'd0;
    logic                  in_valid = 1'b0;
    logic signed [c_W-1:0] in_data = '0;
    logic                  clear_ovr = 1'b0;
    logic signed [c_W-1:0] adc_data;
    logic                  adc_valid;
    logic                  overrange;

    int n_checks = 0;
    int n_fail   = 0;

    adc_block_averager #(
        .ADC_WIDTH   (c_W),
        .LOG2_MAX_AVG(10),
        .VALID_CYCLES(c_VALIDN)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .enable   (enable),
        .log2_avg (log2_avg),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clear_ovr(clear_ovr),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .overrange(overrange)
    );

    always #5 clk = ~clk;

    // One-cycle sample strobe; returns at the t+1 sample point.
    task automatic send(input logic signed [c_W-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts consecutive high cycles of adc_valid from the current sample point.
    task automatic count_high(output int n);
        n = 0;
        while (adc_valid === 1'b1 && n < 16) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic int floor_mean(input longint sum, input int k);
        longint n;
        longint q;
        n = longint'(1) << k;
        q = sum / n;
        if ((sum % n) != 0 && sum < 0) q = q - 1;
        return int'(q);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (adc_data !== '0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", adc_data); end
        n_checks++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", adc_valid); end
        n_checks++; if (overrange !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrange); end
        resetn = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_k0();
        int n;
        log2_avg = 4'd0;
        n_checks++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL k0_idle_valid: got %b expected 0", adc_valid); end
        send(18'sd100);
        n_checks++; if (adc_data !== 18'sd100) begin n_fail++; $display("FAIL k0_data_100: got %0d expected 100", adc_data); end
        n_checks++; if (adc_valid !== 1'b1) begin n_fail++; $display("FAIL k0_valid_rise1: got %b expected 1", adc_valid); end
        count_high(n);
        n_checks++; if (n != c_VALIDN) begin n_fail++; $display("FAIL k0_width1: got %0d expected %0d", n, c_VALIDN); end
        repeat (3) @(negedge clk);
        send(-18'sd5);
        n_checks++; if (adc_data !== -18'sd5) begin n_fail++; $display("FAIL k0_data_m5: got %0d expected -5", adc_data); end
        count_high(n);
        n_checks++; if (n != c_VALIDN) begin n_fail++; $display("FAIL k0_width2: got %0d expected %0d", n, c_VALIDN); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_floor_k2();
        int n;
        logic signed [c_W-1:0] pos [4];
        logic signed [c_W-1:0] neg [4];
        pos = '{18'sd1, 18'sd2, 18'sd3, 18'sd3};
        neg = '{-18'sd1, -18'sd1, -18'sd1, -18'sd2};
        log2_avg = 4'd2;
        for (int i = 0; i < 3; i++) send(pos[i]);
        n_checks++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL k2_midblock_valid: got %b expected 0", adc_valid); end
        send(pos[3]);
        n_checks++; if (adc_data !== 18'sd2) begin n_fail++; $display("FAIL k2_floor_pos: got %0d expected 2", adc_data); end
        count_high(n);
        n_checks++; if (n != c_VALIDN) begin n_fail++; $display("FAIL k2_width: got %0d expected %0d", n, c_VALIDN); end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) send(neg[i]);
        n_checks++; if (adc_data !== -18'sd2) begin n_fail++; $display("FAIL k2_floor_neg: got %0d expected -2", adc_data); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_fullscale();
        logic early;
        early = 1'b0;
        log2_avg = 4'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            in_data = c_MAX;
            @(negedge clk);
            if (i < 1023 && adc_valid !== 1'b0) early = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++; if (early) begin n_fail++; $display("FAIL fs_early_valid: got 1 expected 0"); end
        n_checks++; if (adc_data !== c_MAX) begin n_fail++; $display("FAIL fs_pos: got %0d expected 131071", adc_data); end
        n_checks++; if (adc_valid !== 1'b1) begin n_fail++; $display("FAIL fs_pos_valid: got %b expected 1", adc_valid); end
        n_checks++; if (overrange !== 1'b1) begin n_fail++; $display("FAIL fs_ovr_set: got %b expected 1", overrange); end
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        n_checks++; if (overrange !== 1'b0) begin n_fail++; $display("FAIL fs_ovr_clear: got %b expected 0", overrange); end
        repeat (8) @(negedge clk);
        // Out-of-range k must clamp to the 1024-sample maximum.
        log2_avg = 4'd15;
        in_valid = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            in_data = c_MIN;
            @(negedge clk);
            if (i < 1023 && adc_valid !== 1'b0) early = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++; if (early) begin n_fail++; $display("FAIL fs_clamp_early: got 1 expected 0"); end
        n_checks++; if (adc_data !== c_MIN) begin n_fail++; $display("FAIL fs_neg: got %0d expected -131072", adc_data); end
        repeat (8) @(negedge clk);
        clear_ovr = 1'b1;
        @(negedge clk);
        n_checks++; if (overrange !== 1'b0) begin n_fail++; $display("FAIL fs_ovr_clear2: got %b expected 0", overrange); end
        // Over-range while disabled, together with clear: set must win.
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = c_MAX;
        @(negedge clk);
        in_valid  = 1'b0;
        clear_ovr = 1'b0;
        n_checks++; if (overrange !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b expected 1", overrange); end
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [5:0] exp_pat;
        exp_pat = 6'b111101;
        log2_avg = 4'd0;
        in_valid = 1'b1;
        in_data  = 18'sd7;
        @(negedge clk); pat[0] = adc_valid; in_data = 18'sd8;
        @(negedge clk); pat[1] = adc_valid; in_data = 18'sd9;
        @(negedge clk); pat[2] = adc_valid; in_valid = 1'b0;
        for (int i = 3; i < 6; i++) begin
            @(negedge clk);
            pat[i] = adc_valid;
        end
        n_checks++; if (pat !== exp_pat) begin n_fail++; $display("FAIL b2b_pattern: got %b expected %b (bit0 first)", pat, exp_pat); end
        n_checks++; if (adc_data !== 18'sd9) begin n_fail++; $display("FAIL b2b_data: got %0d expected 9", adc_data); end
        @(negedge clk);
        n_checks++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b expected 0", adc_valid); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_disrupt();
        int n;
        logic early;
        log2_avg = 4'd3;
        for (int i = 0; i < 5; i++) send(18'sd1000);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = 18'sd5000;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        enable   = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(18'sd10);
            if (i < 7 && adc_valid !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early) begin n_fail++; $display("FAIL dis_enable_early: got 1 expected 0"); end
        n_checks++; if (adc_data !== 18'sd10) begin n_fail++; $display("FAIL dis_enable_data: got %0d expected 10", adc_data); end
        count_high(n);
        repeat (3) @(negedge clk);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) log2_avg = 4'd1;
            send((i < 3) ? 18'sd20 : 18'sd4);
            if (i < 7 && adc_valid !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early) begin n_fail++; $display("FAIL dis_k_change_early: got 1 expected 0"); end
        n_checks++; if (adc_data !== 18'sd10) begin n_fail++; $display("FAIL dis_k_change_data: got %0d expected 10", adc_data); end
        count_high(n);
        repeat (3) @(negedge clk);
        send(18'sd6);
        send(18'sd9);
        n_checks++; if (adc_data !== 18'sd7) begin n_fail++; $display("FAIL dis_new_k: got %0d expected 7", adc_data); end
        // Disable during HOLD: valid drops next cycle, data is kept.
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (adc_valid !== 1'b0 || adc_data !== 18'sd7) begin
            n_fail++; $display("FAIL dis_hold_drop: got valid=%b data=%0d expected valid=0 data=7", adc_valid, adc_data);
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int k, n, exp_mean, width;
        longint sum;
        logic signed [c_W-1:0] v;
        logic exp_ovr, early;
        clear_ovr = 1'b1;
        @(negedge clk);
        clear_ovr = 1'b0;
        exp_ovr = 1'b0;
        for (int blk = 0; blk < 12; blk++) begin
            log2_avg = 4'($urandom_range(0, 5));
            k = int'(log2_avg);
            n = 1 << k;
            sum = 0;
            early = 1'b0;
            for (int i = 0; i < n; i++) begin
                v = (($urandom & 32'hF) == 0) ? c_MAX : c_W'($urandom);
                if (v == c_MAX || v == c_MIN) exp_ovr = 1'b1;
                sum += longint'(v);
                if (i > 0 && $urandom_range(0, 3) == 0) log2_avg = 4'($urandom_range(0, 5));
                send(v);
                if (i < n - 1) begin
                    if (adc_valid !== 1'b0) early = 1'b1;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            exp_mean = floor_mean(sum, k);
            n_checks++; if (early) begin n_fail++; $display("FAIL rnd_early blk%0d: got valid=1 expected 0", blk); end
            n_checks++; if (adc_data !== c_W'(exp_mean)) begin
                n_fail++; $display("FAIL rnd_mean blk%0d k=%0d: got %0d expected %0d", blk, k, adc_data, exp_mean);
            end
            n_checks++; if (overrange !== exp_ovr) begin n_fail++; $display("FAIL rnd_ovr blk%0d: got %b expected %b", blk, overrange, exp_ovr); end
            count_high(width);
            n_checks++; if (width != c_VALIDN) begin n_fail++; $display("FAIL rnd_width blk%0d: got %0d expected %0d", blk, width, c_VALIDN); end
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic seen;
        log2_avg = 4'd0;
        send(c_MAX);
        n_checks++; if (adc_valid !== 1'b1 || overrange !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got valid=%b ovr=%b expected 1 1", adc_valid, overrange);
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++; if (adc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", adc_valid); end
        n_checks++; if (adc_data !== '0) begin n_fail++; $display("FAIL rst_async_data: got %0d expected 0", adc_data); end
        n_checks++; if (overrange !== 1'b0) begin n_fail++; $display("FAIL rst_async_ovr: got %b expected 0", overrange); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (adc_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rst_no_pulse: got valid=1 expected 0"); end
    endtask

    initial begin
        test_reset();
        test_k0();
        test_floor_k2();
        test_fullscale();
        test_back_to_back();
        test_disrupt();
        test_random();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
